// File: rtl/eaglesong_permutation_iter.sv
// Iterative Eaglesong permutation: one round per cycle over a 16x32-bit state, NUM_ROUNDS rounds.
// Round constants come from an external combinational ROM addressed by rc_round.
module eaglesong_permutation_iter #(
  parameter int unsigned  NUM_ROUNDS = 43,
  parameter logic [255:0] BIT_MATRIX =
    256'h47d7643c321e190fcb50a5a892d4896a84b5458de511755ffd78bebc9f5e8faf
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic [5:0]   rc_round,
  input  logic [511:0] rc_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

  // Circulant rotation amounts, word j at [5*j +: 5], word 0 in the low bits.
  localparam logic [79:0] ROT_A = {5'd1,  5'd7,  5'd7,  5'd12, 5'd4,  5'd4,  5'd12, 5'd18,
                                   5'd3,  5'd17, 5'd3,  5'd27, 5'd3,  5'd4,  5'd13, 5'd2};
  localparam logic [79:0] ROT_B = {5'd13, 5'd8,  5'd17, 5'd27, 5'd31, 5'd7,  5'd18, 5'd22,
                                   5'd12, 5'd26, 5'd8,  5'd31, 5'd14, 5'd19, 5'd22, 5'd4};

  state_e       fsm_q, fsm_d;
  logic [511:0] st_q, st_d;
  logic [5:0]   rnd_q, rnd_d;
  logic [511:0] round_out;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    return (x << n) | (x >> (6'd32 - {1'b0, n}));
  endfunction

  always_comb begin
    logic [31:0] t;
    logic [31:0] u;
    logic [31:0] v [16];
    logic [31:0] x;
    logic [31:0] y;
    round_out = '0;
    for (int j = 0; j < 16; j++) begin
      t = '0;
      for (int i = 0; i < 16; i++) begin
        if (BIT_MATRIX[16*i + j]) t = t ^ st_q[32*i +: 32];
      end
      u    = t ^ rotl32(t, ROT_A[5*j +: 5]) ^ rotl32(t, ROT_B[5*j +: 5]);
      v[j] = u ^ rc_data[32*j +: 32];
    end
    for (int k = 0; k < 8; k++) begin
      x = rotl32(v[2*k] + v[2*k+1], 5'd8);
      y = rotl32(v[2*k+1], 5'd24) + x;
      round_out[64*k +: 32]      = x;
      round_out[64*k + 32 +: 32] = y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      st_q  <= '0;
      rnd_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      st_q  <= st_d;
      rnd_q <= rnd_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    st_d      = st_q;
    rnd_d     = rnd_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_state = '0;
    rc_round  = '0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d  = in_state;
          rnd_d = '0;
          fsm_d = RUN;
        end
      end
      RUN: begin
        rc_round = rnd_q;
        st_d     = round_out;
        rnd_d    = rnd_q + 6'd1;
        if (rnd_q == LAST_ROUND) begin
          rnd_d = '0;
          fsm_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_state = st_q;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_eaglesong_permutation_iter.sv
// Directed bench for eaglesong_permutation_iter: a 43-round core against a bit-level reference,
// and a 1-round core against a hand-derived vector.
module tb_eaglesong_permutation_iter;

  localparam logic [255:0] MAT =
    256'h47d7643c321e190fcb50a5a892d4896a84b5458de511755ffd78bebc9f5e8faf;
  localparam int RA [16] = '{2, 13, 4, 3, 27, 3, 17, 3, 18, 12, 4, 4, 12, 7, 7, 1};
  localparam int RB [16] = '{4, 22, 19, 14, 31, 8, 26, 12, 22, 18, 7, 31, 27, 17, 8, 13};
  localparam int NR = 43;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [511:0] in_state, rc_data, out_state;
  logic [5:0]   rc_round;
  logic         rc_zero;
  logic         in1_valid, in1_ready, out1_valid, out1_ready;
  logic [511:0] in1_state, rc1_data, out1_state;
  logic [5:0]   rc1_round;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic [511:0] rom(input logic [5:0] r);
    logic [511:0] o;
    logic [31:0]  w;
    for (int j = 0; j < 16; j++) begin
      w = ({26'd0, r} + 32'd1) * 32'h9E3779B9 + j * 32'h7F4A7C15;
      o[32*j +: 32] = w ^ {w[15:0], w[31:16]};
    end
    return o;
  endfunction

  assign rc_data  = rc_zero ? '0 : rom(rc_round);
  assign rc1_data = '0;

  eaglesong_permutation_iter #(.NUM_ROUNDS(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .rc_round(rc_round), .rc_data(rc_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state));

  eaglesong_permutation_iter #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready), .in_state(in1_state),
    .rc_round(rc1_round), .rc_data(rc1_data), .out_valid(out1_valid), .out_ready(out1_ready),
    .out_state(out1_state));

  // Reference round computed bit by bit: matrix as GF(2) parity, rotations as index arithmetic.
  function automatic logic [511:0] ref_round(input logic [511:0] s, input logic [511:0] rc);
    logic [31:0] t, u, x, y;
    logic [31:0] v [16];
    logic [511:0] r;
    for (int j = 0; j < 16; j++) begin
      t = '0;
      for (int b = 0; b < 32; b++)
        for (int i = 0; i < 16; i++)
          t[b] = t[b] ^ (MAT[16*i + j] & s[32*i + b]);
      for (int b = 0; b < 32; b++)
        u[b] = t[b] ^ t[(b - RA[j] + 32) % 32] ^ t[(b - RB[j] + 32) % 32];
      v[j] = u ^ rc[32*j +: 32];
    end
    for (int k = 0; k < 8; k++) begin
      x = v[2*k] + v[2*k+1];
      x = {x[23:0], x[31:24]};
      y = {v[2*k+1][7:0], v[2*k+1][31:8]} + x;
      r[64*k +: 32]      = x;
      r[64*k + 32 +: 32] = y;
    end
    return r;
  endfunction

  function automatic logic [511:0] ref_perm(input logic [511:0] s);
    logic [511:0] st = s;
    for (int r = 0; r < NR; r++) st = ref_round(st, rom(6'(r)));
    return st;
  endfunction

  function automatic logic [511:0] pattern(input int n);
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[32*i +: 32] = 32'(n) * 32'h10203040 + 32'(i) * 32'h01010101 + 32'h5A;
    return p;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; rc_zero = 1'b1;
    in1_valid = 1'b0; out1_ready = 1'b0; in1_state = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (rc_round !== 6'd0) begin n_bad++; $display("FAIL reset_rc_round: got %0d want 0", rc_round); end
    n_cmp++; if (out_state !== '0) begin n_bad++; $display("FAIL reset_out_state: got %h want 0", out_state); end
    n_cmp++; if (in1_ready !== 1'b1 || out1_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_dut1: in_ready %b out_valid %b want 1/0", in1_ready, out1_valid);
    end
  endtask

  task automatic test_zero_state;
    int cyc;
    rc_zero = 1'b1; in_state = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    n_cmp++; if (cyc !== NR) begin n_bad++; $display("FAIL zero_latency: got %0d want %0d", cyc, NR); end
    n_cmp++; if (out_state !== '0) begin n_bad++; $display("FAIL zero_out_state: got %h want 0", out_state); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++; $display("FAIL zero_release: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_single_round;
    logic [511:0] exp1;
    exp1 = {32'h03200320, 32'h00200300, 32'h00000000, 32'h00000000,
            32'h1180A280, 32'h0000A280, 32'h49100610, 32'h48100200,
            32'h09100910, 32'h00100900, 32'h09010901, 32'h00010900,
            32'h11401A40, 32'h08401A00, 32'h41205620, 32'h40201600};
    n_cmp++; if (ref_round(512'h1, '0) !== exp1) begin
      n_bad++; $display("FAIL model_single_round: got %h want %h", ref_round(512'h1, '0), exp1);
    end
    in1_state = 512'h1; in1_valid = 1'b1;
    tick();
    in1_valid = 1'b0;
    n_cmp++; if (out1_valid !== 1'b0) begin n_bad++; $display("FAIL r1_early_valid: got %b want 0", out1_valid); end
    tick();
    n_cmp++; if (out1_valid !== 1'b1) begin n_bad++; $display("FAIL r1_valid: got %b want 1", out1_valid); end
    n_cmp++; if (out1_state !== exp1) begin n_bad++; $display("FAIL r1_state: got %h want %h", out1_state, exp1); end
    out1_ready = 1'b1; tick(); out1_ready = 1'b0;
  endtask

  task automatic test_full_rounds_and_stall;
    logic [511:0] s, exp;
    int rc_bad, busy_bad, stall_bad;
    rc_bad = 0; busy_bad = 0; stall_bad = 0;
    rc_zero = 1'b0;
    for (int i = 0; i < 16; i++) s[32*i +: 32] = 32'(i);
    exp = ref_perm(s);
    in_state = s; in_valid = 1'b1;
    tick();
    in_state = ~s;
    for (int k = 0; k < NR; k++) begin
      if (rc_round !== 6'(k)) rc_bad++;
      if (in_ready !== 1'b0) busy_bad++;
      if (k == 5) in_valid = 1'b0;
      tick();
    end
    n_cmp++; if (rc_bad != 0) begin n_bad++; $display("FAIL full_rc_round_seq: got %0d bad steps want 0", rc_bad); end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL full_busy_in_ready: got %0d high want 0", busy_bad); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL full_latency: out_valid %b want 1", out_valid); end
    n_cmp++; if (out_state !== exp) begin n_bad++; $display("FAIL full_state: got %h want %h", out_state, exp); end
    for (int k = 0; k < 10; k++) begin
      tick();
      if (out_valid !== 1'b1 || out_state !== exp || in_ready !== 1'b0) stall_bad++;
    end
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL stall_hold: got %0d bad cycles want 0", stall_bad); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    logic [511:0] exp;
    in_state = pattern(7); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rc_round !== 6'd0) begin
      n_bad++; $display("FAIL midrst_state: in_ready %b out_valid %b rc_round %0d want 1/0/0",
                        in_ready, out_valid, rc_round);
    end
    exp = ref_perm(pattern(8));
    in_state = pattern(8); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(cyc);
    n_cmp++; if (cyc !== NR) begin n_bad++; $display("FAIL midrst_latency: got %0d want %0d", cyc, NR); end
    n_cmp++; if (out_state !== exp) begin n_bad++; $display("FAIL midrst_state_out: got %h want %h", out_state, exp); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [511:0] exp [3];
    int acc [3];
    int sent, got, since, cyc, rc_bad;
    logic fire_in, fire_out;
    sent = 0; got = 0; since = 99; cyc = 0; rc_bad = 0;
    for (int n = 0; n < 3; n++) exp[n] = ref_perm(pattern(20 + n));
    out_ready = 1'b1; in_valid = 1'b1; in_state = pattern(20);
    while (got < 3 && cyc < 400) begin
      fire_in  = in_valid && in_ready;
      fire_out = out_valid && out_ready;
      if (fire_out) begin
        n_cmp++; if (out_state !== exp[got]) begin
          n_bad++; $display("FAIL b2b_state_%0d: got %h want %h", got, out_state, exp[got]);
        end
        got++;
      end
      tick();
      cyc++;
      if (fire_in) begin
        acc[sent] = cyc; sent++; since = 0;
        if (sent == 3) in_valid = 1'b0;
        else in_state = pattern(20 + sent);
      end else begin
        since++;
      end
      if (since < NR && rc_round !== 6'(since)) rc_bad++;
    end
    out_ready = 1'b0;
    n_cmp++; if (got != 3 || sent != 3) begin
      n_bad++; $display("FAIL b2b_timeout: got %0d outputs %0d inputs want 3/3", got, sent);
    end else begin
      n_cmp++; if (acc[1] - acc[0] != NR + 2) begin
        n_bad++; $display("FAIL b2b_gap0: got %0d want %0d", acc[1] - acc[0], NR + 2);
      end
      n_cmp++; if (acc[2] - acc[1] != NR + 2) begin
        n_bad++; $display("FAIL b2b_gap1: got %0d want %0d", acc[2] - acc[1], NR + 2);
      end
    end
    n_cmp++; if (rc_bad != 0) begin n_bad++; $display("FAIL b2b_rc_round_seq: got %0d bad steps want 0", rc_bad); end
  endtask

  initial begin
    test_reset();
    test_zero_state();
    test_single_round();
    test_full_rounds_and_stall();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
